// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: program counter, IF/ID pipeline register and the
// RUN / HALT / FAULT control that handles stall, branch redirect, end of
// program and misaligned branch targets.
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'd0,
    parameter int          MEM_BYTES = 16,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    input  logic [31:0] Instruction,
    output logic [63:0] Inst_Address,
    output logic [63:0] IFID_PC,
    output logic [31:0] IFID_Instruction,
    output logic        IFID_valid,
    output logic        halted,
    output logic        misaligned
);

    // Highest byte address at which a whole word can still be fetched.
    localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 4);

    typedef enum logic [1:0] {
        S_RUN,
        S_HALT,
        S_FAULT
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;

    logic target_aligned;
    logic target_in_range;
    logic pc_in_range;

    assign target_aligned  = (branch_target[1:0] == 2'b00);
    assign target_in_range = (branch_target <= LAST_ADDR);
    assign pc_in_range     = (pc_q <= LAST_ADDR);

    // Next-state, next-PC and IF/ID update; branch beats range check beats stall.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case/if tree leaves one unassigned, which would infer a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;

        case (state_q)
            S_RUN: begin
                if (branch_taken) begin
                    // Either outcome squashes the instruction being fetched.
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = NOP_INSTR;
                    if (!target_aligned) begin
                        state_d = S_FAULT;
                    end else begin
                        pc_d      = branch_target;
                        ifid_pc_d = 64'd0;
                    end
                end else if (!pc_in_range) begin
                    // Ran off the end of the image: stop without capturing.
                    state_d      = S_HALT;
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = NOP_INSTR;
                end else if (!stall) begin
                    ifid_instr_d = Instruction;
                    ifid_pc_d    = pc_q;
                    ifid_valid_d = 1'b1;
                    pc_d         = pc_q + 64'd4;
                end
            end

            S_HALT: begin
                // Stall is irrelevant here; only a branch can move the PC.
                ifid_valid_d = 1'b0;
                if (branch_taken) begin
                    if (!target_aligned) begin
                        state_d      = S_FAULT;
                        ifid_instr_d = NOP_INSTR;
                    end else begin
                        pc_d = branch_target;
                        if (target_in_range) begin
                            state_d = S_RUN;
                        end
                    end
                end
            end

            S_FAULT: begin
                // Sticky until reset; everything is frozen.
                ifid_valid_d = 1'b0;
            end

            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    // State, PC and IF/ID registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_RUN;
            pc_q         <= RESET_PC;
            ifid_pc_q    <= 64'd0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign Inst_Address     = pc_q;
    assign IFID_PC          = ifid_pc_q;
    assign IFID_Instruction = ifid_instr_q;
    assign IFID_valid       = ifid_valid_q;
    assign halted           = (state_q == S_HALT);
    assign misaligned       = (state_q == S_FAULT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a driver applies directed and
// random stimulus and pushes expectations from a behavioural model; a monitor
// pops and compares them after every clock edge.
module tb_instruction_fetch_unit;

    localparam int          MEM_BYTES = 16;
    localparam logic [63:0] LAST      = 64'(MEM_BYTES - 4);
    localparam logic [31:0] NOP       = 32'h00000013;
    localparam logic [31:0] ROM [4]   = '{32'h02853483, 32'h009A84B3,
                                          32'h00148493, 32'h02953423};

    logic        clk = 1'b0;
    logic        reset, stall, branch_taken;
    logic [63:0] branch_target;
    logic [31:0] Instruction;
    logic [63:0] Inst_Address, IFID_PC;
    logic [31:0] IFID_Instruction;
    logic        IFID_valid, halted, misaligned;

    int n_checks = 0;
    int n_errors = 0;

    instruction_fetch_unit #(
        .RESET_PC (64'd0),
        .MEM_BYTES(MEM_BYTES),
        .NOP_INSTR(NOP)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .Instruction     (Instruction),
        .Inst_Address    (Inst_Address),
        .IFID_PC         (IFID_PC),
        .IFID_Instruction(IFID_Instruction),
        .IFID_valid      (IFID_valid),
        .halted          (halted),
        .misaligned      (misaligned)
    );

    always #5 clk = ~clk;

    // Combinational byte-addressed memory; words are aligned so a word index suffices.
    assign Instruction = (Inst_Address <= LAST) ? ROM[Inst_Address[3:2]] : 32'h0;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] ipc;
        logic [31:0] ins;
        logic        v;
        logic        h;
        logic        f;
    } status_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] ins;
    } capture_t;

    status_t  status_q[$];
    capture_t cap_q[$];

    // Behavioural model of the fetch stage.
    logic [63:0] m_pc, m_ipc;
    logic [31:0] m_ins;
    logic        m_v, m_h, m_f;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Apply one clock edge to the model using the inputs currently driven.
    task automatic model_edge();
        capture_t c;
        if (reset) begin
            m_pc = 64'd0; m_ipc = 64'd0; m_ins = NOP; m_v = 0; m_h = 0; m_f = 0;
        end else if (m_f) begin
            // frozen
        end else if (branch_taken) begin
            m_v = 0;
            if (branch_target % 4 != 0) begin
                m_f = 1; m_h = 0; m_ins = NOP;
            end else if (m_h) begin
                m_pc = branch_target;
                if (branch_target <= LAST) m_h = 0;
            end else begin
                m_pc = branch_target; m_ins = NOP; m_ipc = 64'd0;
            end
        end else if (m_h) begin
            m_v = 0;
        end else if (m_pc > LAST) begin
            m_h = 1; m_v = 0; m_ins = NOP;
        end else if (!stall) begin
            m_ins = ROM[m_pc / 4];
            m_ipc = m_pc;
            m_v   = 1;
            c.pc  = m_pc;
            c.ins = m_ins;
            cap_q.push_back(c);
            m_pc  = m_pc + 64'd4;
        end
    endtask

    task automatic edge_update();
        status_t s;
        model_edge();
        s.addr = m_pc; s.ipc = m_ipc; s.ins = m_ins; s.v = m_v; s.h = m_h; s.f = m_f;
        status_q.push_back(s);
    endtask

    // Drive inputs on the falling edge, then account for the rising edge.
    task automatic step(input logic r, input logic st, input logic br, input logic [63:0] tgt);
        @(negedge clk);
        reset = r; stall = st; branch_taken = br; branch_target = tgt;
        @(posedge clk);
        edge_update();
    endtask

    // Monitor: compare status every edge; compare a capture whenever IF/ID
    // presents a valid instruction that decode accepted (no stall at that edge).
    initial begin
        status_t  s;
        capture_t c;
        logic     st_at_edge;
        forever begin
            @(posedge clk);
            st_at_edge = stall;
            #1;
            if (status_q.size() == 0) begin
                check("status_queue_empty", 64'd0, 64'd1);
            end else begin
                s = status_q.pop_front();
                check("inst_address", Inst_Address, s.addr);
                check("ifid_valid", 64'(IFID_valid), 64'(s.v));
                check("halted", 64'(halted), 64'(s.h));
                check("misaligned", 64'(misaligned), 64'(s.f));
                check("ifid_pc", IFID_PC, s.ipc);
                check("ifid_instruction", 64'(IFID_Instruction), 64'(s.ins));
            end
            if (IFID_valid && !st_at_edge) begin
                if (cap_q.size() == 0) begin
                    check("unexpected_capture", 64'd1, 64'd0);
                end else begin
                    c = cap_q.pop_front();
                    check("capture_pc", IFID_PC, c.pc);
                    check("capture_instr", 64'(IFID_Instruction), 64'(c.ins));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic        br, st, rs;
        logic [63:0] tgt;
        int          k;

        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 64'd0;
        @(posedge clk);
        edge_update();
        step(1, 0, 0, 0);

        // Sequential fetch to halt.
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0);
            #1;
            if (i == 0) check("seq_first_instr", 64'(IFID_Instruction), 64'h02853483);
        end
        check("seq_halted", 64'(halted), 64'd1);
        check("seq_halt_valid", 64'(IFID_valid), 64'd0);

        // Stall holds PC and IF/ID.
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        #1;
        check("stall_ifid_pc", IFID_PC, 64'd4);
        check("stall_addr", Inst_Address, 64'd8);
        step(0, 0, 0, 0);
        #1;
        check("stall_resume_pc", IFID_PC, 64'd8);
        check("stall_resume_instr", 64'(IFID_Instruction), 64'h00148493);

        // Branch at PC=8 overriding a simultaneous stall.
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 1, 64'd0);
        #1;
        check("br_valid", 64'(IFID_valid), 64'd0);
        check("br_nop", 64'(IFID_Instruction), 64'(NOP));
        check("br_addr", Inst_Address, 64'd0);
        step(0, 0, 0, 0);

        // Restart from HALT.
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        step(0, 1, 1, 64'd4);
        #1;
        check("restart_halted", 64'(halted), 64'd0);
        check("restart_addr", Inst_Address, 64'd4);
        step(0, 0, 0, 0);
        #1;
        check("restart_capture_pc", IFID_PC, 64'd4);

        // Misaligned fault is sticky until reset.
        step(0, 0, 1, 64'd6);
        step(0, 1, 1, 64'd0);
        step(0, 0, 0, 0);
        #1;
        check("fault_sticky", 64'(misaligned), 64'd1);
        check("fault_pc_held", Inst_Address, 64'd8);
        step(1, 0, 0, 0);
        #1;
        check("fault_cleared", 64'(misaligned), 64'd0);

        // Asynchronous reset between edges.
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_addr", Inst_Address, 64'd0);
        check("async_valid", 64'(IFID_valid), 64'd0);
        check("async_instr", 64'(IFID_Instruction), 64'(NOP));
        check("async_ifid_pc", IFID_PC, 64'd0);
        @(posedge clk);
        edge_update();
        step(0, 0, 0, 0);
        #1;
        check("async_first_capture", 64'(IFID_Instruction), 64'h02853483);

        // Random episodes.
        for (int ep = 0; ep < 12; ep++) begin
            step(1, 0, 0, 0);
            for (int n = 0; n < 50; n++) begin
                rs = ($urandom_range(0, 99) == 0);
                st = ($urandom_range(0, 3) == 0);
                br = ($urandom_range(0, 99) < 12);
                k  = $urandom_range(0, 9);
                if (k >= 8 && $urandom_range(0, 3) != 0) k = k - 8;
                case (k)
                    6:       tgt = 64'hFFFF_FFFF_FFFF_FFFC;
                    7:       tgt = {32'($urandom), 32'($urandom)} & ~64'd3;
                    8:       tgt = 64'd2;
                    9:       tgt = 64'(4 * $urandom_range(0, 3) + 1);
                    default: tgt = 64'(4 * k);
                endcase
                step(rs, st, br, tgt);
            end
        end

        step(0, 0, 0, 0);
        #2;
        check("status_queue_drained", 64'(status_q.size()), 64'd0);
        check("capture_queue_drained", 64'(cap_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
